// File: rtl/tile_pixel_walker.sv
// Walks a TILE_SIZE x TILE_SIZE tile in raster order, stepping three edge functions and
// depth by addition only, and emits one fragment per covered pixel.
// Coordinate vectors are packed {x, y, z}, FX_TOTAL_BITS each, with x in the MSBs.
module tile_pixel_walker #(
  parameter int FX_TOTAL_BITS = 16,
  parameter int FX_FRAC_BITS  = 4,
  parameter int TILE_SIZE     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              vld_in,
  output logic                              rdy_in,
  input  logic [3*FX_TOTAL_BITS-1:0]        in_abs_pos,
  input  logic [3*FX_TOTAL_BITS-1:0]        in_delta_0,
  input  logic [3*FX_TOTAL_BITS-1:0]        in_delta_1,
  input  logic [3*FX_TOTAL_BITS-1:0]        in_delta_2,
  input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_0,
  input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_1,
  input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_2,
  input  logic [3:0]                        in_color,
  input  logic signed [FX_TOTAL_BITS-1:0]   in_dzdx,
  input  logic signed [FX_TOTAL_BITS-1:0]   in_dzdy,
  input  logic [2*FX_TOTAL_BITS-1:0]        in_z_current,
  output logic                              vld_out,
  input  logic                              rdy_out,
  output logic [FX_TOTAL_BITS-1:0]          out_x,
  output logic [FX_TOTAL_BITS-1:0]          out_y,
  output logic signed [2*FX_TOTAL_BITS-1:0] out_z,
  output logic [3:0]                        out_color,
  output logic                              out_tile_done
);

  localparam int FX = FX_TOTAL_BITS;
  localparam int EW = 2 * FX_TOTAL_BITS;
  localparam int CW = $clog2(TILE_SIZE);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t state_reg, state_next;

  logic          accept;
  logic          adv;
  logic          scan_step;
  logic          drain_exit;
  logic          last_col;
  logic          last_px;
  logic          covered;
  logic [2:0]    edge_neg;
  logic [CW-1:0] col_reg, row_reg;

  logic [3*FX-1:0] delta_in [3];
  logic [EW-1:0]   edge_in  [3];

  assign delta_in[0] = in_delta_0;
  assign delta_in[1] = in_delta_1;
  assign delta_in[2] = in_delta_2;
  assign edge_in[0]  = in_edge_0;
  assign edge_in[1]  = in_edge_1;
  assign edge_in[2]  = in_edge_2;

  // z components of the coordinate vectors carry no information for this stage
  logic unused_bits;
  assign unused_bits = ^{in_abs_pos[FX-1:0], in_delta_0[FX-1:0],
                         in_delta_1[FX-1:0], in_delta_2[FX-1:0]};

  // TILE_SIZE is a power of two, so the last index is all ones
  assign last_col = &col_reg;
  assign last_px  = last_col && (&row_reg);
  assign covered  = ~|edge_neg;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rdy_in     = 1'b0;
    accept     = 1'b0;
    scan_step  = 1'b0;
    drain_exit = 1'b0;
    adv        = !vld_out || rdy_out;
    case (state_reg)
      IDLE: begin
        rdy_in = 1'b1;
        if (vld_in) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (adv) begin
          scan_step = 1'b1;
          if (last_px) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (adv) begin
          drain_exit = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- edge steppers
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    logic [FX-1:0]        dx, dy;
    logic signed [EW-1:0] x_step_reg, y_step_reg;
    logic signed [EW-1:0] row_edge_reg, cur_edge_reg, row_edge_next;

    assign dx            = delta_in[gi][3*FX-1:2*FX];
    assign dy            = delta_in[gi][2*FX-1:FX];
    assign row_edge_next = row_edge_reg + y_step_reg;
    assign edge_neg[gi]  = cur_edge_reg[EW-1];

    // x-direction step comes from delta.y and y-direction from delta.x
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_step_reg   <= '0;
        y_step_reg   <= '0;
        row_edge_reg <= '0;
        cur_edge_reg <= '0;
      end else if (accept) begin
        x_step_reg   <= {{FX{dy[FX-1]}}, dy} << FX_FRAC_BITS;
        y_step_reg   <= {{FX{dx[FX-1]}}, dx} << FX_FRAC_BITS;
        row_edge_reg <= edge_in[gi];
        cur_edge_reg <= edge_in[gi];
      end else if (scan_step) begin
        if (last_col) begin
          row_edge_reg <= row_edge_next;
          cur_edge_reg <= row_edge_next;
        end else begin
          cur_edge_reg <= cur_edge_reg + x_step_reg;
        end
      end
    end
  end

  // ---------------------------------------------------------------- depth, counters, output
  logic signed [EW-1:0] zx_step_reg, zy_step_reg;
  logic signed [EW-1:0] row_z_reg, cur_z_reg, row_z_next;
  logic [FX-1:0]        abs_x_reg, abs_y_reg;
  logic [3:0]           color_reg;

  assign row_z_next = row_z_reg + zy_step_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zx_step_reg   <= '0;
      zy_step_reg   <= '0;
      row_z_reg     <= '0;
      cur_z_reg     <= '0;
      abs_x_reg     <= '0;
      abs_y_reg     <= '0;
      color_reg     <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      vld_out       <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_z         <= '0;
      out_color     <= '0;
      out_tile_done <= 1'b0;
    end else begin
      out_tile_done <= 1'b0;
      if (accept) begin
        zx_step_reg <= {{FX{in_dzdx[FX-1]}}, in_dzdx} << FX_FRAC_BITS;
        zy_step_reg <= {{FX{in_dzdy[FX-1]}}, in_dzdy} << FX_FRAC_BITS;
        row_z_reg   <= in_z_current;
        cur_z_reg   <= in_z_current;
        abs_x_reg   <= in_abs_pos[3*FX-1:2*FX];
        abs_y_reg   <= in_abs_pos[2*FX-1:FX];
        color_reg   <= in_color;
        col_reg     <= '0;
        row_reg     <= '0;
      end
      if (scan_step) begin
        if (covered) begin
          vld_out   <= 1'b1;
          out_x     <= abs_x_reg + (FX'(col_reg) << FX_FRAC_BITS);
          out_y     <= abs_y_reg + (FX'(row_reg) << FX_FRAC_BITS);
          out_z     <= cur_z_reg;
          out_color <= color_reg;
        end else begin
          vld_out <= 1'b0;
        end
        if (last_col) begin
          col_reg   <= '0;
          row_reg   <= row_reg + CW'(1);
          row_z_reg <= row_z_next;
          cur_z_reg <= row_z_next;
        end else begin
          col_reg   <= col_reg + CW'(1);
          cur_z_reg <= cur_z_reg + zx_step_reg;
        end
      end
      if (drain_exit) begin
        vld_out       <= 1'b0;
        out_tile_done <= 1'b1;
      end
    end
  end

endmodule
